// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift right, shift left or parallel load each clock.
// Each bit is a 4:1 mux feeding a flip-flop with synchronous clear.
module universal_shift_reg #(
    parameter int DATA_WIDTH = 4,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                  i_clk,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic [SEL_WIDTH-1:0]  sel_mux,
    input  logic                  sr,
    input  logic                  sl,
    output logic [DATA_WIDTH-1:0] q_out
);

    localparam logic [SEL_WIDTH-1:0] MODE_HOLD  = 2'b00;
    localparam logic [SEL_WIDTH-1:0] MODE_RIGHT = 2'b01;
    localparam logic [SEL_WIDTH-1:0] MODE_LEFT  = 2'b10;
    localparam logic [SEL_WIDTH-1:0] MODE_LOAD  = 2'b11;

    logic [DATA_WIDTH-1:0] q_q;
    logic [DATA_WIDTH-1:0] q_d;
    logic [DATA_WIDTH-1:0] right_nbr;
    logic [DATA_WIDTH-1:0] left_nbr;

    // Neighbour feeding each bit: sr enters at the MSB, sl at the LSB.
    assign right_nbr = {sr, q_q[DATA_WIDTH-1:1]};
    assign left_nbr  = {q_q[DATA_WIDTH-2:0], sl};

    always_comb begin
        // NOTE: default assignment first so no path leaves q_d unassigned (no latch).
        q_d = q_q;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            case (sel_mux)
                MODE_HOLD:  q_d[i] = q_q[i];
                MODE_RIGHT: q_d[i] = right_nbr[i];
                MODE_LEFT:  q_d[i] = left_nbr[i];
                MODE_LOAD:  q_d[i] = in[i];
                default:    q_d[i] = q_q[i];
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignment for state so every flop samples pre-edge values.
        if (clr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_out = q_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg: directed mode tests plus a
// randomized run compared each cycle against an arithmetic reference model.
module tb_universal_shift_reg;

    localparam int W = 4;
    localparam logic [W-1:0] MASK = '1;

    logic         clk;
    logic         clr;
    logic [W-1:0] din;
    logic [1:0]   sel;
    logic         sr;
    logic         sl;
    logic [W-1:0] q_out;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] model_q;

    universal_shift_reg #(.DATA_WIDTH(W), .SEL_WIDTH(2)) dut (
        .i_clk   (clk),
        .clr     (clr),
        .in      (din),
        .sel_mux (sel),
        .sr      (sr),
        .sl      (sl),
        .q_out   (q_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the model, and settle just after the edge.
    task automatic drive(input logic c, input logic [1:0] s, input logic [W-1:0] d,
                         input logic r, input logic l);
        clr = c;
        sel = s;
        din = d;
        sr  = r;
        sl  = l;
        if (c) begin
            model_q = '0;
        end else begin
            case (s)
                2'd1:    model_q = (model_q >> 1) | (W'(r) << (W - 1));
                2'd2:    model_q = ((model_q << 1) | W'(l)) & MASK;
                2'd3:    model_q = d;
                default: model_q = model_q;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 2'b11, 4'hA, 1'b0, 1'b0);
        drive(1'b0, 2'b11, 4'hA, 1'b0, 1'b0);
        total++;
        if (q_out !== 4'hA) begin
            bad++;
            $display("FAIL reset_preload: got %h want %h", q_out, 4'hA);
        end
        drive(1'b1, 2'b00, 4'h0, 1'b0, 1'b0);
        total++;
        if (q_out !== 4'h0) begin
            bad++;
            $display("FAIL reset_clear: got %h want %h", q_out, 4'h0);
        end
        drive(1'b1, 2'b11, 4'hF, 1'b1, 1'b1);
        total++;
        if (q_out !== 4'h0) begin
            bad++;
            $display("FAIL reset_over_load: got %h want %h", q_out, 4'h0);
        end
    endtask

    task automatic test_load_hold();
        drive(1'b0, 2'b11, 4'b1011, 1'b0, 1'b0);
        total++;
        if (q_out !== 4'b1011) begin
            bad++;
            $display("FAIL load: got %b want %b", q_out, 4'b1011);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 4'b0000, i[0], ~i[0]);
            total++;
            if (q_out !== 4'b1011) begin
                bad++;
                $display("FAIL hold[%0d]: got %b want %b", i, q_out, 4'b1011);
            end
        end
    endtask

    task automatic test_shift_right();
        logic [W-1:0] exp_tab [3] = '{4'b1101, 4'b0110, 4'b0011};
        logic         sr_tab  [3] = '{1'b1, 1'b0, 1'b0};
        drive(1'b0, 2'b11, 4'b1011, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b01, 4'hF, sr_tab[i], 1'b1);
            total++;
            if (q_out !== exp_tab[i]) begin
                bad++;
                $display("FAIL shift_right[%0d]: got %b want %b", i, q_out, exp_tab[i]);
            end
        end
    endtask

    task automatic test_shift_left();
        logic [W-1:0] exp_tab [3] = '{4'b0110, 4'b1101, 4'b1011};
        logic         sl_tab  [3] = '{1'b0, 1'b1, 1'b1};
        drive(1'b0, 2'b11, 4'b1011, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b10, 4'h0, 1'b1, sl_tab[i]);
            total++;
            if (q_out !== exp_tab[i]) begin
                bad++;
                $display("FAIL shift_left[%0d]: got %b want %b", i, q_out, exp_tab[i]);
            end
        end
    endtask

    task automatic test_fill_flush();
        logic [W-1:0] fill_tab  [4] = '{4'h8, 4'hC, 4'hE, 4'hF};
        logic [W-1:0] flush_tab [4] = '{4'hE, 4'hC, 4'h8, 4'h0};
        drive(1'b1, 2'b00, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b01, 4'h5, 1'b1, i[0]);
            total++;
            if (q_out !== fill_tab[i]) begin
                bad++;
                $display("FAIL fill[%0d]: got %h want %h", i, q_out, fill_tab[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b10, 4'hA, ~i[0], 1'b0);
            total++;
            if (q_out !== flush_tab[i]) begin
                bad++;
                $display("FAIL flush[%0d]: got %h want %h", i, q_out, flush_tab[i]);
            end
        end
    endtask

    task automatic test_random();
        logic         c;
        logic [1:0]   s;
        logic [W-1:0] d;
        drive(1'b1, 2'b00, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 250; i++) begin
            c = ($urandom_range(0, 15) == 0);
            s = 2'($urandom_range(0, 3));
            d = W'($urandom);
            drive(c, s, d, 1'($urandom), 1'($urandom));
            total++;
            if (q_out !== model_q) begin
                bad++;
                $display("FAIL random[%0d]: clr=%b sel=%b got %h want %h",
                         i, c, s, q_out, model_q);
            end
        end
    endtask

    initial begin
        clr     = 1'b0;
        sel     = 2'b00;
        din     = '0;
        sr      = 1'b0;
        sl      = 1'b0;
        model_q = '0;
        @(negedge clk);
        test_reset();
        test_load_hold();
        test_shift_right();
        test_shift_left();
        test_fill_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parameterised universal shift register, default 4 bits.
- Four modes per clock, chosen by a 2-bit select: hold, shift right with serial input, shift left with serial input, parallel load.
- Built from one mux-plus-flip-flop bit slice per stage; used as the register stage in datapath and serial I/O front ends.

Parameters:
- DATA_WIDTH, 4, register width in bits; must be >= 2.
- SEL_WIDTH, 2, mode select width; fixed at 2, do not override.

Ports:
- i_clk  input  1  system clock; all state changes on its rising edge.
- clr  input  1  synchronous, active-high clear.
- in  input  DATA_WIDTH  parallel load data.
- sel_mux  input  SEL_WIDTH  mode select.
- sr  input  1  serial input for shift right; enters the MSB.
- sl  input  1  serial input for shift left; enters the LSB.
- q_out  output  DATA_WIDTH  register contents.

Interface notes:
- One clock domain (i_clk). Reset is synchronous and active-high.
- No handshake. Mode is taken every cycle.

Behaviour:
- q_out is driven directly by the internal register; no combinational path from any input to q_out.
- At each rising edge of i_clk, q_out updates as follows, in priority order:
  - clr=1: q_out <= 0. Clear overrides every sel_mux value.
  - sel_mux=2'b00 (hold): q_out <= q_out.
  - sel_mux=2'b01 (shift right): q_out <= {sr, q_out[DATA_WIDTH-1:1]}. Old LSB is discarded.
  - sel_mux=2'b10 (shift left): q_out <= {q_out[DATA_WIDTH-2:0], sl}. Old MSB is discarded.
  - sel_mux=2'b11 (parallel load): q_out <= in.
- Latency: one clock. The result of a mode is visible on q_out after the edge where the inputs were sampled.
- Reset value: q_out = 0.
- Before the first clr or load, q_out is undefined (X in simulation). The bench must assert clr for at least one edge first.
- Asserting clr in the middle of a shift sequence zeroes the register at that edge. Shifting or loading resumes from 0 on the first edge after clr deasserts.
- sr is ignored in every mode except 01; sl is ignored in every mode except 10; in is ignored in every mode except 11.
- Structure:
  - One 4:1 mux per bit, select = sel_mux.
  - Mux inputs, in select order 00/01/10/11: q[i], right neighbour input (q[i+1], or sr for the MSB), left neighbour input (q[i-1], or sl for the LSB), in[i].
  - Each mux feeds a D flip-flop with synchronous clear.
- X/Z on sel_mux is not a supported input. The mux must default to hold for any value not listed above.
- Unknown sel_mux must never corrupt the register once the select is valid again.

Test Plan:
- Reset: run sel_mux=11, in=4'hA for 2 clocks, then clr=1 for 1 clock -> q_out=4'h0 after the clr edge. With clr=1 and sel_mux=11, in=4'hF -> q_out stays 4'h0.
- Load and hold: clr=0, sel_mux=11, in=4'b1011 -> q_out=4'b1011 after 1 edge. Then sel_mux=00, in=4'b0000 for 3 edges -> q_out stays 4'b1011.
- Shift right: from q_out=4'b1011, sel_mux=01, sr=1,0,0 on successive edges -> q_out = 4'b1101, 4'b0110, 4'b0011.
- Shift left: from q_out=4'b1011, sel_mux=10, sl=0,1,1 on successive edges -> q_out = 4'b0110, 4'b1101, 4'b1011.
- Serial fill/flush:
  - From 4'h0, sel_mux=01 with sr=1 for 4 edges -> q_out=4'hF.
  - Then sel_mux=10 with sl=0 for 4 edges -> q_out=4'h0.
  - sl toggling during the right shifts and sr toggling during the left shifts has no effect.
- Random mode: sel_mux, in, sr and sl randomised every cycle, with clr pulsed 1 cycle randomly, 200+ cycles -> q_out matches a cycle-accurate reference model every cycle.
